// File: rtl/amb_ifetch.sv
// Instruction prefetch stage: fetches words from a variable-latency memory over req/ack,
// buffers them in a small FIFO and hands {opcode, operand, pc} to the core via valid/ready.
module amb_ifetch #(
    parameter int                ADDR_W   = 8,
    parameter int                OPCODE_W = 4,
    parameter int                QDEPTH   = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         mem_req,
    output logic [ADDR_W-1:0]            mem_addr,
    input  logic                         mem_ack,
    input  logic [OPCODE_W+ADDR_W-1:0]   mem_rdata,
    output logic                         inst_valid,
    input  logic                         inst_ready,
    output logic [OPCODE_W-1:0]          opcode,
    output logic [ADDR_W-1:0]            operand,
    output logic [ADDR_W-1:0]            inst_pc,
    input  logic                         redirect,
    input  logic [ADDR_W-1:0]            redirect_pc
);

    // Handshakes: a memory transfer completes on any edge where mem_req & mem_ack;
    // mem_addr holds while mem_req & !mem_ack. The core takes the head on inst_valid & inst_ready.
    localparam int INST_W = OPCODE_W + ADDR_W;
    localparam int PTR_W  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W  = $clog2(QDEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(QDEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] fetch_pc;

    logic [INST_W-1:0] word_q [QDEPTH];
    logic [ADDR_W-1:0] pc_q   [QDEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;

    logic push;
    logic pop;
    logic room_after;

    assign inst_valid = (count != '0);
    assign push       = (state == REQ) && mem_ack && !redirect;
    assign pop        = inst_valid && inst_ready && !redirect;
    // A slot still exists after this cycle's push, counting a same-cycle pop.
    assign room_after = pop || (count < (FULL - CNT_W'(1)));

    assign opcode  = inst_valid ? word_q[rd_ptr][INST_W-1 -: OPCODE_W] : '0;
    assign operand = inst_valid ? word_q[rd_ptr][ADDR_W-1:0]           : '0;
    assign inst_pc = inst_valid ? pc_q[rd_ptr]                         : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            mem_addr <= RESET_PC;
            mem_req  <= 1'b0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
            case (state)
                IDLE: begin
                    state    <= REQ;
                    mem_req  <= 1'b1;
                    mem_addr <= redirect_pc;
                end
                REQ: begin
                    mem_req <= 1'b1;
                    if (mem_ack) begin
                        mem_addr <= redirect_pc;
                    end else begin
                        state <= DROP;
                    end
                end
                DROP: begin
                    // The stale request completes this cycle; restart straight at the new target.
                    if (mem_ack) begin
                        state    <= REQ;
                        mem_addr <= redirect_pc;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end else begin
            case (state)
                IDLE: begin
                    if (count < FULL) begin
                        state    <= REQ;
                        mem_req  <= 1'b1;
                        mem_addr <= fetch_pc;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        fetch_pc <= fetch_pc + ADDR_W'(1);
                        if (room_after) begin
                            mem_addr <= fetch_pc + ADDR_W'(1);
                        end else begin
                            state   <= IDLE;
                            mem_req <= 1'b0;
                        end
                    end
                end
                DROP: begin
                    if (mem_ack) begin
                        state    <= REQ;
                        mem_addr <= fetch_pc;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: head outputs are gated by inst_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            word_q[wr_ptr] <= mem_rdata;
            pc_q[wr_ptr]   <= fetch_pc;
        end
    end

endmodule

// File: tb/tb_amb_ifetch.sv
// Bench for amb_ifetch: behavioural instruction memory, program-order scoreboard
// (the core must see pc, pc+1, ... from the last redirect target), and scenario tasks.
module tb_amb_ifetch;
    localparam int ADDR_W   = 8;
    localparam int OPCODE_W = 4;
    localparam int QDEPTH   = 4;
    localparam int INST_W   = OPCODE_W + ADDR_W;
    localparam int EXP_W    = ADDR_W + INST_W;
    localparam logic [ADDR_W-1:0] RESET_PC = 8'h00;

    logic                clk;
    logic                rst;
    logic                mem_req;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_ack;
    logic [INST_W-1:0]   mem_rdata;
    logic                inst_valid;
    logic                inst_ready;
    logic [OPCODE_W-1:0] opcode;
    logic [ADDR_W-1:0]   operand;
    logic [ADDR_W-1:0]   inst_pc;
    logic                redirect;
    logic [ADDR_W-1:0]   redirect_pc;

    int n_checks = 0;
    int n_errors = 0;

    logic [INST_W-1:0] imem [256];
    logic [EXP_W-1:0]  exp_q [$];
    logic [ADDR_W-1:0] ack_log [$];
    logic [EXP_W-1:0]  mon_e;

    bit          ack_tied = 1'b0;
    bit          rand_lat = 1'b0;
    int          ack_lat  = 0;
    int          cur_lat  = 0;
    int          wait_cnt = 0;
    bit          hs_prev  = 1'b0;
    bit          prev_req = 1'b0;
    bit          prev_ack = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;
    bit          saw_fff  = 1'b0;
    int          n_pops   = 0;

    amb_ifetch #(
        .ADDR_W   (ADDR_W),
        .OPCODE_W (OPCODE_W),
        .QDEPTH   (QDEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .opcode      (opcode),
        .operand     (operand),
        .inst_pc     (inst_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Memory model and scoreboard, both evaluated at the falling edge.
    initial begin : mem_and_monitor
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (hs_prev || !mem_req) begin
                wait_cnt = 0;
                cur_lat  = rand_lat ? int'($urandom_range(0, 3)) : ack_lat;
            end
            if (ack_tied) mem_ack = 1'b1;
            else          mem_ack = mem_req && (wait_cnt >= cur_lat);
            mem_rdata = imem[mem_addr];
            if (mem_req && !mem_ack) wait_cnt++;
            hs_prev = mem_req && mem_ack;
            if (hs_prev) ack_log.push_back(mem_addr);

            if (!rst) begin
                if (prev_req && !prev_ack && mem_req) begin
                    n_checks++;
                    if (mem_addr !== prev_addr) begin
                        n_errors++;
                        $display("FAIL addr_stable: mem_addr %h, held value %h", mem_addr, prev_addr);
                    end
                end
                if (inst_valid && ({opcode, operand} == 12'hFFF)) saw_fff = 1'b1;
                if (inst_valid && inst_ready && !redirect) begin
                    n_pops++;
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_errors++;
                        $display("FAIL pop_order: pc %h inst %h%h consumed, nothing expected", inst_pc, opcode, operand);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if ({inst_pc, opcode, operand} !== mon_e) begin
                            n_errors++;
                            $display("FAIL pop_order: got pc/inst %h/%h%h, expected %h/%h",
                                     inst_pc, opcode, operand, mon_e[EXP_W-1 -: ADDR_W], mon_e[INST_W-1:0]);
                        end
                    end
                end
            end
            prev_req  = mem_req;
            prev_ack  = mem_ack;
            prev_addr = mem_addr;
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_imem();
        for (int i = 0; i < 256; i++) imem[i] = 12'($urandom_range(0, 12'hFFE));
    endtask

    // Program order from a start address: each consumed entry is {pc, imem[pc]}.
    task automatic exp_fill(input logic [ADDR_W-1:0] start, input int n);
        logic [ADDR_W-1:0] pc;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            pc = start + ADDR_W'(i);
            exp_q.push_back({pc, imem[pc]});
        end
    endtask

    task automatic setup(input bit tied, input int lat, input bit rnd, input logic ready);
        tick();
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        inst_ready  = ready;
        ack_tied    = tied;
        ack_lat     = lat;
        rand_lat    = rnd;
        repeat (2) tick();
        fill_imem();
        ack_log.delete();
        saw_fff = 1'b0;
        n_pops  = 0;
    endtask

    task automatic wait_acks(input int n, input string what);
        int t = 0;
        while (ack_log.size() < n && t < 60) begin
            tick();
            t++;
        end
        n_checks++;
        if (ack_log.size() < n) begin
            n_errors++;
            $display("FAIL %s: memory handshakes %0d, required %0d", what, ack_log.size(), n);
        end
    endtask

    task automatic wait_valid(input string what);
        int t = 0;
        while (!inst_valid && t < 30) begin
            tick();
            t++;
        end
        n_checks++;
        if (!inst_valid) begin
            n_errors++;
            $display("FAIL %s: inst_valid never rose", what);
        end
    endtask

    function automatic logic [ADDR_W-1:0] log_at(input int i);
        return (ack_log.size() > i) ? ack_log[i] : 'x;
    endfunction

    task automatic do_redirect(input logic [ADDR_W-1:0] target);
        redirect    = 1'b1;
        redirect_pc = target;
        exp_fill(target, 512);
        tick();
        redirect = 1'b0;
    endtask

    // Scenarios
    task automatic test_reset();
        setup(1'b1, 0, 1'b0, 1'b1);
        n_checks++; if (mem_req !== 1'b0)      begin n_errors++; $display("FAIL reset_req: %b, required 0", mem_req); end
        n_checks++; if (mem_addr !== RESET_PC) begin n_errors++; $display("FAIL reset_addr: %h, required %h", mem_addr, RESET_PC); end
        n_checks++; if (inst_valid !== 1'b0)   begin n_errors++; $display("FAIL reset_valid: %b, required 0", inst_valid); end
        n_checks++; if (opcode !== '0)         begin n_errors++; $display("FAIL reset_opcode: %h, required 0", opcode); end
        n_checks++; if (operand !== '0)        begin n_errors++; $display("FAIL reset_operand: %h, required 0", operand); end
        n_checks++; if (inst_pc !== '0)        begin n_errors++; $display("FAIL reset_pc: %h, required 0", inst_pc); end
    endtask

    task automatic test_first_fetch();
        logic [19:0] tbl [4];
        tbl[0] = 20'h1A3_00;
        tbl[1] = 20'h2B4_01;
        tbl[2] = 20'h3C5_02;
        tbl[3] = 20'h4D6_03;
        setup(1'b1, 0, 1'b0, 1'b1);
        imem[0] = 12'h1A3;
        imem[1] = 12'h2B4;
        imem[2] = 12'h3C5;
        imem[3] = 12'h4D6;
        exp_fill(RESET_PC, 64);
        rst = 1'b0;
        tick();
        n_checks++; if (mem_req !== 1'b1)    begin n_errors++; $display("FAIL first_req: mem_req %b after edge 1, required 1", mem_req); end
        n_checks++; if (inst_valid !== 1'b0) begin n_errors++; $display("FAIL first_early: inst_valid %b after edge 1, required 0", inst_valid); end
        tick();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (!inst_valid || {opcode, operand, inst_pc} !== tbl[i]) begin
                n_errors++;
                $display("FAIL first_seq[%0d]: valid %b op/opd/pc %h/%h/%h, required %h", i, inst_valid, opcode, operand, inst_pc, tbl[i]);
            end
            tick();
        end
        for (int j = 0; j < 10; j++) begin
            n_checks++;
            if (inst_valid !== 1'b1) begin n_errors++; $display("FAIL stream_gap: inst_valid %b in cycle %0d, required 1", inst_valid, j); end
            tick();
        end
    endtask

    task automatic test_backpressure();
        setup(1'b1, 0, 1'b0, 1'b0);
        exp_fill(RESET_PC, 64);
        rst = 1'b0;
        repeat (12) tick();
        n_checks++; if (ack_log.size() != QDEPTH) begin n_errors++; $display("FAIL bp_count: %0d requests, required %0d", ack_log.size(), QDEPTH); end
        for (int i = 0; i < QDEPTH; i++) begin
            n_checks++;
            if (log_at(i) !== ADDR_W'(i)) begin n_errors++; $display("FAIL bp_addr[%0d]: %h, required %h", i, log_at(i), ADDR_W'(i)); end
        end
        n_checks++; if (mem_req !== 1'b0)    begin n_errors++; $display("FAIL bp_req: mem_req %b when full, required 0", mem_req); end
        n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 8'h00) begin n_errors++; $display("FAIL bp_head: valid %b pc %h, required 1/00", inst_valid, inst_pc); end
        inst_ready = 1'b1;
        wait_acks(QDEPTH + 1, "bp_resume");
        n_checks++; if (log_at(QDEPTH) !== 8'h04) begin n_errors++; $display("FAIL bp_resume_addr: %h, required 04", log_at(QDEPTH)); end
        repeat (6) tick();
        n_checks++; if (n_pops < QDEPTH) begin n_errors++; $display("FAIL bp_drain: %0d pops, required at least %0d", n_pops, QDEPTH); end
    endtask

    task automatic test_slow_mem();
        int last   = -1;
        int pulses = 0;
        logic [ADDR_W-1:0] last_pc = '0;
        setup(1'b0, 3, 1'b0, 1'b1);
        exp_fill(RESET_PC, 64);
        rst = 1'b0;
        repeat (6) tick();
        for (int c = 0; c < 40; c++) begin
            tick();
            if (inst_valid) begin
                if (last >= 0) begin
                    n_checks++;
                    if (c - last != 4) begin n_errors++; $display("FAIL slow_period: gap %0d cycles, required 4", c - last); end
                    n_checks++;
                    if (inst_pc !== last_pc + 8'd1) begin n_errors++; $display("FAIL slow_pc: %h, required %h", inst_pc, last_pc + 8'd1); end
                end
                last    = c;
                last_pc = inst_pc;
                pulses++;
            end
        end
        n_checks++; if (pulses != 10) begin n_errors++; $display("FAIL slow_pulses: %0d, required 10", pulses); end
    endtask

    task automatic test_redirect_outstanding();
        setup(1'b0, 2, 1'b0, 1'b0);
        imem[2] = 12'hFFF;
        exp_fill(RESET_PC, 64);
        rst = 1'b0;
        wait_acks(2, "ro_prefill");
        n_checks++; if (inst_valid !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 8'h02) begin
            n_errors++; $display("FAIL ro_pre: valid %b req %b addr %h, required 1/1/02", inst_valid, mem_req, mem_addr);
        end
        do_redirect(8'h40);
        n_checks++; if (inst_valid !== 1'b0) begin n_errors++; $display("FAIL ro_flush: inst_valid %b, required 0", inst_valid); end
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 8'h02) begin n_errors++; $display("FAIL ro_hold: req %b addr %h, required 1/02", mem_req, mem_addr); end
        inst_ready = 1'b1;
        wait_acks(4, "ro_refetch");
        n_checks++; if (log_at(2) !== 8'h02) begin n_errors++; $display("FAIL ro_drop_addr: %h, required 02", log_at(2)); end
        n_checks++; if (log_at(3) !== 8'h40) begin n_errors++; $display("FAIL ro_next_addr: %h, required 40", log_at(3)); end
        wait_valid("ro_first");
        n_checks++; if (inst_pc !== 8'h40) begin n_errors++; $display("FAIL ro_first_pc: %h, required 40", inst_pc); end
        repeat (8) tick();
        n_checks++; if (saw_fff !== 1'b0) begin n_errors++; $display("FAIL ro_stale: dropped word FFF was presented"); end
    endtask

    task automatic test_redirect_same_cycle();
        setup(1'b1, 0, 1'b0, 1'b1);
        exp_fill(RESET_PC, 64);
        rst = 1'b0;
        repeat (5) tick();
        n_checks++; if (inst_valid !== 1'b1 || mem_req !== 1'b1) begin n_errors++; $display("FAIL sc_pre: valid %b req %b, required 1/1", inst_valid, mem_req); end
        do_redirect(8'h10);
        n_checks++; if (inst_valid !== 1'b0) begin n_errors++; $display("FAIL sc_flush: inst_valid %b, required 0", inst_valid); end
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 8'h10) begin n_errors++; $display("FAIL sc_addr: req %b addr %h, required 1/10", mem_req, mem_addr); end
        tick();
        n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 8'h10) begin n_errors++; $display("FAIL sc_first: valid %b pc %h, required 1/10", inst_valid, inst_pc); end
    endtask

    task automatic test_wrap();
        logic [ADDR_W-1:0] w [3];
        w[0] = 8'hFE;
        w[1] = 8'hFF;
        w[2] = 8'h00;
        setup(1'b1, 0, 1'b0, 1'b1);
        exp_fill(RESET_PC, 64);
        rst = 1'b0;
        repeat (4) tick();
        // Two redirects back to back: the second target must win.
        redirect    = 1'b1;
        redirect_pc = 8'h80;
        exp_fill(8'h80, 64);
        tick();
        do_redirect(8'hFE);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (mem_req !== 1'b1 || mem_addr !== w[i]) begin n_errors++; $display("FAIL wrap_addr[%0d]: req %b addr %h, required 1/%h", i, mem_req, mem_addr, w[i]); end
            tick();
            n_checks++;
            if (inst_valid !== 1'b1 || inst_pc !== w[i]) begin n_errors++; $display("FAIL wrap_pc[%0d]: valid %b pc %h, required 1/%h", i, inst_valid, inst_pc, w[i]); end
        end
    endtask

    task automatic test_reset_mid();
        setup(1'b0, 2, 1'b0, 1'b0);
        exp_fill(RESET_PC, 64);
        rst = 1'b0;
        wait_acks(2, "rm_prefill");
        n_checks++; if (inst_valid !== 1'b1 || mem_req !== 1'b1) begin n_errors++; $display("FAIL rm_pre: valid %b req %b, required 1/1", inst_valid, mem_req); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (mem_req !== 1'b0)      begin n_errors++; $display("FAIL rm_req: %b, required 0", mem_req); end
        n_checks++; if (mem_addr !== RESET_PC) begin n_errors++; $display("FAIL rm_addr: %h, required %h", mem_addr, RESET_PC); end
        n_checks++; if (inst_valid !== 1'b0)   begin n_errors++; $display("FAIL rm_valid: %b, required 0", inst_valid); end
        n_checks++; if ({opcode, operand, inst_pc} !== '0) begin n_errors++; $display("FAIL rm_head: %h/%h/%h, required 0", opcode, operand, inst_pc); end
        repeat (2) tick();
        ack_log.delete();
        inst_ready = 1'b1;
        exp_fill(RESET_PC, 64);
        rst = 1'b0;
        wait_acks(1, "rm_restart");
        n_checks++; if (log_at(0) !== RESET_PC) begin n_errors++; $display("FAIL rm_restart_addr: %h, required %h", log_at(0), RESET_PC); end
        wait_valid("rm_first");
        n_checks++; if (inst_pc !== RESET_PC) begin n_errors++; $display("FAIL rm_first_pc: %h, required %h", inst_pc, RESET_PC); end
    endtask

    task automatic test_random();
        setup(1'b0, 0, 1'b1, 1'b1);
        exp_fill(RESET_PC, 512);
        rst = 1'b0;
        for (int c = 0; c < 400; c++) begin
            tick();
            inst_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) begin
                redirect    = 1'b1;
                redirect_pc = 8'($urandom_range(0, 255));
                exp_fill(redirect_pc, 512);
            end else begin
                redirect = 1'b0;
            end
        end
        redirect   = 1'b0;
        inst_ready = 1'b1;
        repeat (10) tick();
        n_checks++; if (n_pops < 40) begin n_errors++; $display("FAIL rand_progress: %0d instructions consumed, required at least 40", n_pops); end
    endtask

    initial begin
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        inst_ready  = 1'b0;
        fill_imem();
        test_reset();
        test_first_fetch();
        test_backpressure();
        test_slow_mem();
        test_redirect_outstanding();
        test_redirect_same_cycle();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
